// File: rtl/perf_counter_bank_pkg.sv
// Shared configuration for the performance counter bank: CSR width, counter geometry and
// the channel enumeration the core uses when wiring event pulses.
package perf_counter_bank_pkg;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned PERF_CNT_LEN = 64;
  localparam int unsigned PERF_CNT_INC = 1;
  localparam int unsigned PERF_NUM_CNT = 8;

  typedef enum logic [2:0] {
    EVT_CYCLE,
    EVT_INSTRET,
    EVT_STALL,
    EVT_BRANCH_MISS,
    EVT_DCACHE_MISS,
    EVT_ICACHE_MISS,
    EVT_LOAD,
    EVT_STORE
  } perf_evt_e;
endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: half-word CSR write, gated increment and a wrap pulse for the
// overflow flag. A write always wins over a same-cycle increment.
module perf_counter_cell #(
  parameter int unsigned XLEN    = perf_counter_bank_pkg::XLEN,
  parameter int unsigned CNT_W   = perf_counter_bank_pkg::PERF_CNT_LEN,
  parameter int unsigned CNT_INC = perf_counter_bank_pkg::PERF_CNT_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             wr_en,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wr_data,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);
  import perf_counter_bank_pkg::*;

  logic [CNT_W:0] sum;

  assign sum  = {1'b0, cnt} + (CNT_W+1)'(CNT_INC);
  assign wrap = inc && !wr_en && sum[CNT_W];

  if (CNT_W > XLEN) begin : g_split
    always_ff @(posedge clk) begin
      if (!rst_n)       cnt <= '0;
      else if (wr_en) begin
        if (wr_hi)      cnt[CNT_W-1:XLEN] <= wr_data[CNT_W-XLEN-1:0];
        else            cnt[XLEN-1:0]     <= wr_data;
      end
      else if (inc)     cnt <= sum[CNT_W-1:0];
    end
  end else begin : g_flat
    // Single-word counter: hi writes have nowhere to land and are dropped.
    always_ff @(posedge clk) begin
      if (!rst_n)       cnt <= '0;
      else if (wr_en) begin
        if (!wr_hi)     cnt <= wr_data;
      end
      else if (inc)     cnt <= sum[CNT_W-1:0];
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters behind a CSR-style port: inhibit mask, sticky overflow flags with
// IRQ, and a shadow of the upper half so a lo-then-hi read pair is coherent.
module perf_counter_bank #(
  parameter  int unsigned XLEN    = perf_counter_bank_pkg::XLEN,
  parameter  int unsigned CNT_W   = perf_counter_bank_pkg::PERF_CNT_LEN,
  parameter  int unsigned NUM_CNT = perf_counter_bank_pkg::PERF_NUM_CNT,
  parameter  int unsigned CNT_INC = perf_counter_bank_pkg::PERF_CNT_INC,
  localparam int unsigned IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               inhibit_we,
  input  logic [NUM_CNT-1:0] inhibit_wd,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_hi,
  input  logic [XLEN-1:0]    wr_data,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_hi,
  output logic [XLEN-1:0]    rd_data,
  output logic               rd_valid,
  output logic [NUM_CNT-1:0] ovf_flags,
  input  logic [NUM_CNT-1:0] ovf_clr,
  output logic               ovf_irq
);
  import perf_counter_bank_pkg::*;

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic [NUM_CNT-1:0]            inhibit, wrap, wr_sel;
  logic                          wr_ok, rd_ok;
  logic [CNT_W-1:0]              rd_ent;
  logic [XLEN-1:0]               rd_next;

  assign wr_ok  = 32'(wr_idx) < NUM_CNT;
  assign rd_ok  = 32'(rd_idx) < NUM_CNT;
  assign rd_ent = rd_ok ? cnt[rd_idx] : '0;

  always_comb begin
    wr_sel = '0;
    if (wr_en && wr_ok) wr_sel[wr_idx] = 1'b1;
  end

  perf_counter_cell #(.XLEN(XLEN), .CNT_W(CNT_W), .CNT_INC(CNT_INC)) u_cell [NUM_CNT-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (event_i & ~inhibit),
    .wr_en  (wr_sel),
    .wr_hi  (wr_hi),
    .wr_data(wr_data),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  if (CNT_W > XLEN) begin : g_shadow
    logic [CNT_W-XLEN-1:0] shadow;
    logic [IDX_W-1:0]      shadow_idx;
    logic                  shadow_vld, hit;

    assign hit = shadow_vld && (shadow_idx == rd_idx);

    always_comb begin
      rd_next = '0;
      if (rd_ok) begin
        if (!rd_hi)   rd_next = rd_ent[XLEN-1:0];
        else if (hit) rd_next = XLEN'(shadow);
        else          rd_next = XLEN'(rd_ent[CNT_W-1:XLEN]);
      end
    end

    // A write landing on the channel being tagged this cycle leaves the shadow stale.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow     <= '0;
        shadow_idx <= '0;
        shadow_vld <= 1'b0;
      end else if (rd_en && rd_ok && !rd_hi) begin
        shadow     <= rd_ent[CNT_W-1:XLEN];
        shadow_idx <= rd_idx;
        shadow_vld <= !(wr_en && wr_ok && (wr_idx == rd_idx));
      end else if ((rd_en && rd_hi && hit) || (wr_en && wr_ok && (wr_idx == shadow_idx))) begin
        shadow_vld <= 1'b0;
      end
    end
  end else begin : g_noshadow
    always_comb begin
      rd_next = '0;
      if (rd_ok && !rd_hi) rd_next = rd_ent[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inhibit   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      ovf_flags <= '0;
      ovf_irq   <= 1'b0;
    end else begin
      if (inhibit_we) inhibit <= inhibit_wd;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
      ovf_flags <= (ovf_flags & ~ovf_clr) | wrap;
      ovf_irq   <= |ovf_flags;
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: reset, count, wrap/IRQ, coherent pair reads,
// write-vs-event priority, inhibit and out-of-range indices.
module tb_perf_counter_bank;
  localparam int NUM_CNT = 6;
  localparam int IDX_W   = 3;

  logic               clk, rst_n;
  logic [NUM_CNT-1:0] event_i, inhibit_wd, ovf_flags, ovf_clr;
  logic               inhibit_we, wr_en, wr_hi, rd_en, rd_hi, rd_valid, ovf_irq;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [31:0]        wr_data, rd_data;
  logic [31:0]        exp_lo [NUM_CNT];

  int n_cmp = 0;
  int n_err = 0;

  perf_counter_bank #(.XLEN(32), .CNT_W(64), .NUM_CNT(NUM_CNT), .CNT_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .event_i(event_i),
    .inhibit_we(inhibit_we), .inhibit_wd(inhibit_wd),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data), .rd_valid(rd_valid),
    .ovf_flags(ovf_flags), .ovf_clr(ovf_clr), .ovf_irq(ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input bit hi, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx[IDX_W-1:0]; wr_hi = hi; wr_data = d;
    tick();
    wr_en = 1'b0; wr_hi = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int idx, input bit hi, input logic [31:0] exp);
    rd_en = 1'b1; rd_idx = idx[IDX_W-1:0]; rd_hi = hi;
    tick();
    rd_en = 1'b0; rd_hi = 1'b0;
    chk(tag, rd_data, exp);
    chk({tag, "_vld"}, rd_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; event_i = '1; inhibit_we = 1'b0; inhibit_wd = '0; ovf_clr = '0;
    wr_en = 1'b0; wr_idx = '0; wr_hi = 1'b0; wr_data = '0;
    rd_en = 1'b1; rd_idx = '0; rd_hi = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) exp_lo[i] = '0;

    // 1: reset holds everything at zero even with events and reads active
    repeat (3) tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_irq", ovf_irq, 0);
    chk("rst_flags", ovf_flags, 0);
    rd_en = 1'b0; event_i = '0; rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_CNT; i++) rd_chk($sformatf("rst_cnt%0d", i), i, 0, 0);
    tick();
    chk("rd_valid_pulse", rd_valid, 0);
    event_i[0] = 1'b1;
    repeat (10) tick();
    event_i[0] = 1'b0;
    exp_lo[0] = 10;
    rd_chk("cnt10_lo", 0, 0, 10);
    rd_chk("cnt10_hi", 0, 1, 0);

    // 2: 64-bit wrap sets sticky flag, IRQ follows one cycle later
    wr(3, 0, 32'hFFFF_FFFF);
    wr(3, 1, 32'hFFFF_FFFF);
    chk("no_ovf_on_write", ovf_flags, 0);
    event_i[3] = 1'b1;
    tick();
    event_i[3] = 1'b0;
    chk("wrap_flag", ovf_flags, 6'b001000);
    chk("wrap_irq_lag", ovf_irq, 0);
    tick();
    chk("wrap_irq", ovf_irq, 1);
    rd_chk("wrap_lo", 3, 0, 0);
    rd_chk("wrap_hi", 3, 1, 0);
    ovf_clr[3] = 1'b1;
    tick();
    ovf_clr[3] = 1'b0;
    chk("clr_flag", ovf_flags, 0);
    tick();
    chk("clr_irq", ovf_irq, 0);

    // 3: coherent pair across a 32-bit carry while counting every cycle
    wr(1, 0, 32'hFFFF_FFFF);
    event_i[1] = 1'b1;
    rd_chk("coh_lo", 1, 0, 32'hFFFF_FFFF);
    rd_chk("coh_hi_shadow", 1, 1, 0);
    rd_chk("coh_hi_live", 1, 1, 1);
    event_i[1] = 1'b0;
    exp_lo[1] = 2;

    // 4: write beats same-cycle event; a write to the tagged channel kills the shadow
    event_i[2] = 1'b1;
    wr(2, 0, 5);
    event_i[2] = 1'b0;
    exp_lo[2] = 5;
    rd_chk("wr_vs_evt", 2, 0, 5);
    wr(2, 1, 7);
    rd_chk("shadow_inval", 2, 1, 7);

    // 5: inhibit freezes counting but still allows writes
    inhibit_we = 1'b1; inhibit_wd = 6'b000001;
    tick();
    inhibit_we = 1'b0;
    event_i[0] = 1'b1;
    repeat (20) tick();
    event_i[0] = 1'b0;
    rd_chk("inhibit_hold", 0, 0, 10);
    wr(0, 0, 100);
    rd_chk("inhibit_wr", 0, 0, 100);
    inhibit_we = 1'b1; inhibit_wd = '0;
    tick();
    inhibit_we = 1'b0;
    event_i[0] = 1'b1;
    repeat (3) tick();
    event_i[0] = 1'b0;
    exp_lo[0] = 103;
    rd_chk("inhibit_clr", 0, 0, 103);

    // 6: out-of-range indices
    rd_chk("oob_rd6", 6, 0, 0);
    rd_chk("oob_rd7_hi", 7, 1, 0);
    wr(6, 0, 32'hDEAD_BEEF);
    wr(7, 1, 32'hCAFE_F00D);
    for (int i = 0; i < NUM_CNT; i++) rd_chk($sformatf("oob_keep%0d", i), i, 0, exp_lo[i]);
    rd_chk("oob_keep2_hi", 2, 1, 7);
    chk("end_flags", ovf_flags, 0);

    // reset in the middle of a read drops it
    rd_en = 1'b1; rd_idx = 3'd0; rst_n = 1'b0;
    tick();
    rd_en = 1'b0; rst_n = 1'b1;
    chk("rst_mid_read_vld", rd_valid, 0);
    chk("rst_mid_read_data", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
